bar_renderer: RTL and testbench

- Sequences the 1-bit framebuffer's write port: on each start request, sweeps every pixel once and writes the audio-spectrum bar-graph bitmap, one pixel per clock.
- Bar heights arrive from the spectrum stage through a shadow register bank. The bank is snapshotted at render start so a frame never tears.
- Sits between the FFT/magnitude stage and the framebuffer's write side. The display scan-out owns the read side independently.

---
 rtl/bar_renderer.sv | 161 ++++++++++++++++
 tb/tb_bar_renderer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bar_renderer.sv
// Framebuffer write-side sequencer: on start, sweeps every pixel once and writes a
// bar-graph bitmap from a snapshot of the shadow height bank, one pixel per clock.
module bar_renderer #(
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480,
  parameter int ADDR_WIDTH    = $clog2(SCREEN_WIDTH*SCREEN_HEIGHT),
  parameter int NUM_BARS      = 16,
  parameter int BAR_GAP       = 4,
  parameter int HEIGHT_WIDTH  = $clog2(SCREEN_HEIGHT+1)
) (
  input  logic                        wrclk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        bin_wr_en,
  input  logic [$clog2(NUM_BARS)-1:0] bin_idx,
  input  logic [HEIGHT_WIDTH-1:0]     bin_height,
  output logic                        busy,
  output logic                        done,
  output logic                        fb_wr_en,
  output logic [ADDR_WIDTH-1:0]       fb_wr_addr,
  output logic                        fb_wr_data
);

  // state    | meaning
  // ST_IDLE  | waiting for start; outputs hold last pixel
  // ST_RENDER| one framebuffer write per cycle, raster order
  // ST_DONE  | single cycle with done=1 after the final write
  typedef enum logic [1:0] {ST_IDLE, ST_RENDER, ST_DONE} state_t;

  localparam int SLOT_W = SCREEN_WIDTH / NUM_BARS;
  localparam int X_W    = $clog2(SCREEN_WIDTH);
  localparam int Y_W    = $clog2(SCREEN_HEIGHT);
  localparam int C_W    = $clog2(SLOT_W);
  localparam int I_W    = $clog2(NUM_BARS);
  localparam int CMP_W  = HEIGHT_WIDTH + 1;

  localparam logic [X_W-1:0] X_LAST = X_W'(SCREEN_WIDTH - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(SCREEN_HEIGHT - 1);
  localparam logic [C_W-1:0] C_LAST = C_W'(SLOT_W - 1);

  state_t                  r_state, w_state;
  logic [X_W-1:0]          r_x, w_x;
  logic [Y_W-1:0]          r_y, w_y;
  logic [C_W-1:0]          r_col, w_col;
  logic [I_W-1:0]          r_slot, w_slot;
  logic [ADDR_WIDTH-1:0]   r_addr, w_addr;
  logic                    r_busy, w_busy;
  logic                    r_done, w_done;
  logic                    r_wr_en, w_wr_en;
  logic                    r_data, w_data;
  logic                    w_ld_active;
  logic [HEIGHT_WIDTH-1:0] w_h;
  logic                    w_lit;
  logic [HEIGHT_WIDTH-1:0] w_clamped;
  logic                    w_idx_ok;
  logic [HEIGHT_WIDTH-1:0] r_shadow [NUM_BARS];
  logic [HEIGHT_WIDTH-1:0] r_active [NUM_BARS];

  assign w_clamped = (bin_height > HEIGHT_WIDTH'(SCREEN_HEIGHT)) ?
                     HEIGHT_WIDTH'(SCREEN_HEIGHT) : bin_height;
  assign w_idx_ok  = (32'(bin_idx) < 32'(NUM_BARS));

  always_comb begin
    w_state     = r_state;
    w_x         = r_x;
    w_y         = r_y;
    w_col       = r_col;
    w_slot      = r_slot;
    w_addr      = r_addr;
    w_busy      = r_busy;
    w_done      = 1'b0;
    w_wr_en     = 1'b0;
    w_data      = r_data;
    w_ld_active = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state     = ST_RENDER;
          w_ld_active = 1'b1;
          w_busy      = 1'b1;
          w_wr_en     = 1'b1;
          w_x         = '0;
          w_y         = '0;
          w_col       = '0;
          w_slot      = '0;
          w_addr      = '0;
        end
      end
      ST_RENDER: begin
        if (r_x == X_LAST && r_y == Y_LAST) begin
          w_state = ST_DONE;
          w_busy  = 1'b0;
          w_done  = 1'b1;
        end else begin
          w_wr_en = 1'b1;
          w_addr  = r_addr + 1'b1;
          if (r_x == X_LAST) begin
            w_x    = '0;
            w_col  = '0;
            w_slot = '0;
            w_y    = r_y + 1'b1;
          end else begin
            w_x = r_x + 1'b1;
            if (r_col == C_LAST) begin
              w_col  = '0;
              w_slot = r_slot + 1'b1;
            end else begin
              w_col = r_col + 1'b1;
            end
          end
        end
      end
      ST_DONE: w_state = ST_IDLE;
      default: w_state = ST_IDLE;
    endcase
    // First pixel is computed while the snapshot is still being taken
    w_h   = w_ld_active ? r_shadow[0] : r_active[w_slot];
    w_lit = ({1'b0, w_col} < (C_W+1)'(SLOT_W - BAR_GAP)) &&
            ((CMP_W'(w_y) + CMP_W'(w_h)) >= CMP_W'(SCREEN_HEIGHT));
    if (w_wr_en) w_data = w_lit;
  end

  always_ff @(posedge wrclk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_col   <= '0;
      r_slot  <= '0;
      r_addr  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_wr_en <= 1'b0;
      r_data  <= 1'b0;
      for (int i = 0; i < NUM_BARS; i++) begin
        r_shadow[i] <= '0;
        r_active[i] <= '0;
      end
    end else begin
      r_state <= w_state;
      r_x     <= w_x;
      r_y     <= w_y;
      r_col   <= w_col;
      r_slot  <= w_slot;
      r_addr  <= w_addr;
      r_busy  <= w_busy;
      r_done  <= w_done;
      r_wr_en <= w_wr_en;
      r_data  <= w_data;
      if (w_ld_active) r_active <= r_shadow;
      if (bin_wr_en && w_idx_ok) r_shadow[bin_idx] <= w_clamped;
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign fb_wr_en   = r_wr_en;
  assign fb_wr_addr = r_addr;
  assign fb_wr_data = r_data;

endmodule

// File: tb/tb_bar_renderer.sv
// Bench for bar_renderer on an 8x4 screen with 2 bars, plus a 12x4 / 3-bar
// instance where an out-of-range bin index can be expressed.
module tb_bar_renderer;
  localparam int W = 8, H = 4, NB = 2, GAP = 1, SW = W / NB;

  logic       wrclk = 1'b0, reset = 1'b1, start = 1'b0, bin_wr_en = 1'b0;
  logic [0:0] bin_idx = '0;
  logic [2:0] bin_height = '0;
  logic       busy, done, fb_wr_en, fb_wr_data;
  logic [4:0] fb_wr_addr;

  logic        start3 = 1'b0, bin_wr_en3 = 1'b0;
  logic [1:0]  bin_idx3 = '0;
  logic        busy3, done3, fb3_wr_en, fb3_wr_data;
  logic [5:0]  fb3_wr_addr;
  logic [47:0] mask3 = '0;

  int errors = 0, checks = 0;
  int mshadow[NB];

  always #5 wrclk = ~wrclk;

  bar_renderer #(.SCREEN_WIDTH(W), .SCREEN_HEIGHT(H), .NUM_BARS(NB), .BAR_GAP(GAP)) dut (
    .wrclk(wrclk), .reset(reset), .start(start), .bin_wr_en(bin_wr_en), .bin_idx(bin_idx),
    .bin_height(bin_height), .busy(busy), .done(done), .fb_wr_en(fb_wr_en),
    .fb_wr_addr(fb_wr_addr), .fb_wr_data(fb_wr_data));

  bar_renderer #(.SCREEN_WIDTH(12), .SCREEN_HEIGHT(H), .NUM_BARS(3), .BAR_GAP(GAP)) dut3 (
    .wrclk(wrclk), .reset(reset), .start(start3), .bin_wr_en(bin_wr_en3), .bin_idx(bin_idx3),
    .bin_height(bin_height), .busy(busy3), .done(done3), .fb_wr_en(fb3_wr_en),
    .fb_wr_addr(fb3_wr_addr), .fb_wr_data(fb3_wr_data));

  always @(negedge wrclk) if (fb3_wr_en) mask3[fb3_wr_addr] <= fb3_wr_data;

  typedef struct {
    int start_at; bit start_in_done; bit restart; int rst_at;
    int wr_at; int wr_idx; int wr_h;
  } opt_t;
  typedef struct {
    logic [31:0] mask; int nwr; int ndone; bit addr_ok; bit busy_ok;
    int last_cyc; int done_cyc; int restart_cyc; logic busy_after_rst; logic wr_after_rst;
  } res_t;
  typedef struct { bit w0; int h0; bit w1; int h1; logic [31:0] exp; } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Bitmap straight from the lit rule: column inside the bar and row within height from bottom
  function automatic logic [31:0] model_mask(input int h0, input int h1);
    logic [31:0] m;
    int hh;
    m = '0;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        hh = (x / SW == 0) ? h0 : h1;
        m[y*W + x] = ((x % SW) < (SW - GAP)) && (y >= H - hh);
      end
    return m;
  endfunction

  function automatic logic [47:0] model_mask3(input int h0, input int h1, input int h2);
    logic [47:0] m;
    int hh;
    m = '0;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < 12; x++) begin
        hh = (x / 4 == 0) ? h0 : (x / 4 == 1) ? h1 : h2;
        m[y*12 + x] = ((x % 4) < (4 - GAP)) && (y >= H - hh);
      end
    return m;
  endfunction

  function automatic opt_t dflt();
    opt_t o;
    o.start_at = -1; o.start_in_done = 0; o.restart = 0; o.rst_at = -1;
    o.wr_at = -2; o.wr_idx = 0; o.wr_h = 0;
    return o;
  endfunction

  task automatic put_bin(input int idx, input int h);
    bin_wr_en = 1'b1; bin_idx = idx[0]; bin_height = h[2:0];
    @(posedge wrclk); #1;
    bin_wr_en = 1'b0;
    mshadow[idx] = (h > H) ? H : h;
  endtask

  task automatic run_frame(input opt_t o, output res_t r);
    int rst_cyc;
    rst_cyc = -100;
    r.mask = '0; r.nwr = 0; r.ndone = 0; r.addr_ok = 1; r.busy_ok = 1;
    r.last_cyc = -1; r.done_cyc = -1; r.restart_cyc = -1;
    r.busy_after_rst = 1'bx; r.wr_after_rst = 1'bx;
    start = 1'b1;
    if (o.wr_at == -1) begin
      bin_wr_en = 1'b1; bin_idx = o.wr_idx[0]; bin_height = o.wr_h[2:0];
    end
    @(posedge wrclk); #1;
    for (int cyc = 0; cyc < 45; cyc++) begin
      start = 1'b0; reset = 1'b0; bin_wr_en = 1'b0;
      if (cyc == rst_cyc + 1) begin
        r.busy_after_rst = busy; r.wr_after_rst = fb_wr_en;
      end
      if (fb_wr_en) begin
        if (r.done_cyc >= 0 && r.restart_cyc < 0) r.restart_cyc = cyc;
        if (r.done_cyc < 0) begin
          if (fb_wr_addr !== 5'(r.nwr)) r.addr_ok = 0;
          r.mask[fb_wr_addr] = fb_wr_data;
          if (!busy) r.busy_ok = 0;
          if (fb_wr_addr == 5'd31) r.last_cyc = cyc;
          if (r.nwr == o.start_at) start = 1'b1;
          if (r.nwr == o.rst_at) begin reset = 1'b1; rst_cyc = cyc; end
          if (r.nwr == o.wr_at) begin
            bin_wr_en = 1'b1; bin_idx = o.wr_idx[0]; bin_height = o.wr_h[2:0];
          end
        end
        r.nwr++;
      end
      if (done) begin
        r.ndone++;
        if (r.done_cyc < 0) r.done_cyc = cyc;
        if (busy) r.busy_ok = 0;
        if (o.start_in_done) start = 1'b1;
      end
      if (o.restart && r.done_cyc >= 0 && cyc == r.done_cyc + 1) start = 1'b1;
      @(posedge wrclk); #1;
    end
    start = 1'b0; reset = 1'b0; bin_wr_en = 1'b0;
  endtask

  task automatic drain();
    bit idle;
    idle = 0;
    for (int i = 0; i < 80 && !idle; i++) begin
      if (!busy && !done && !fb_wr_en) idle = 1;
      else begin @(posedge wrclk); #1; end
    end
    chk("drain_to_idle", 64'(idle), 64'd1);
  endtask

  task automatic check_full(input string name, input res_t r, input logic [31:0] exp);
    chk({name, "_mask"}, 64'(r.mask), 64'(exp));
    chk({name, "_nwr"}, 64'(r.nwr), 64'd32);
    chk({name, "_ndone"}, 64'(r.ndone), 64'd1);
    chk({name, "_addr_seq"}, 64'(r.addr_ok), 64'd1);
    chk({name, "_busy"}, 64'(r.busy_ok), 64'd1);
    chk({name, "_done_lat"}, 64'(r.done_cyc - r.last_cyc), 64'd1);
  endtask

  initial begin
    vec_t vt[6];
    res_t r;
    opt_t o;
    logic [31:0] exp;
    bit got;

    for (int i = 0; i < NB; i++) mshadow[i] = 0;

    // Reset held two cycles
    reset = 1'b1;
    repeat (2) @(posedge wrclk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_wr_en", 64'(fb_wr_en), 64'd0);
    chk("rst_addr", 64'(fb_wr_addr), 64'd0);
    reset = 1'b0;
    @(posedge wrclk); #1;

    vt[0] = '{0, 0, 0, 0, 32'h0000_0000};
    vt[1] = '{1, 2, 1, 4, 32'h7777_7070};
    vt[2] = '{1, 0, 1, 1, 32'h7000_0000};
    vt[3] = '{1, 3, 1, 0, 32'h0707_0700};
    vt[4] = '{1, 4, 1, 7, 32'h7777_7777};
    vt[5] = '{0, 0, 1, 2, 32'h7777_0707};
    foreach (vt[i]) begin
      if (vt[i].w0) put_bin(0, vt[i].h0);
      if (vt[i].w1) put_bin(1, vt[i].h1);
      run_frame(dflt(), r);
      check_full($sformatf("vec%0d", i), r, vt[i].exp);
      drain();
    end

    // Shadow write mid-frame does not tear; lands next frame
    put_bin(0, 2); put_bin(1, 4);
    o = dflt(); o.wr_at = 5; o.wr_idx = 0; o.wr_h = 4;
    run_frame(o, r);
    check_full("snap_mid", r, 32'h7777_7070);
    mshadow[0] = 4;
    run_frame(dflt(), r);
    check_full("snap_next", r, 32'h7777_7777);

    // Write in the same cycle as start: snapshot keeps the old value
    o = dflt(); o.wr_at = -1; o.wr_idx = 1; o.wr_h = 0;
    run_frame(o, r);
    check_full("snap_same", r, 32'h7777_7777);
    mshadow[1] = 0;
    run_frame(dflt(), r);
    check_full("snap_same_next", r, 32'h0707_0707);

    // start during render and during done is dropped
    o = dflt(); o.start_at = 5; o.start_in_done = 1;
    run_frame(o, r);
    check_full("start_ignored", r, model_mask(mshadow[0], mshadow[1]));

    // start one cycle after done begins a new frame
    o = dflt(); o.restart = 1;
    run_frame(o, r);
    chk("restart_lat", 64'(r.restart_cyc - r.done_cyc), 64'd2);
    chk("restart_first_mask", 64'(r.mask), 64'(model_mask(mshadow[0], mshadow[1])));
    drain();

    // Reset mid-render
    put_bin(0, 3); put_bin(1, 2);
    o = dflt(); o.rst_at = 10;
    run_frame(o, r);
    chk("rst_mid_nwr", 64'(r.nwr), 64'd11);
    chk("rst_mid_ndone", 64'(r.ndone), 64'd0);
    chk("rst_mid_busy", 64'(r.busy_after_rst), 64'd0);
    chk("rst_mid_wr_en", 64'(r.wr_after_rst), 64'd0);
    for (int i = 0; i < NB; i++) mshadow[i] = 0;
    run_frame(dflt(), r);
    check_full("rst_mid_cleared", r, 32'h0);

    // Randomised heights, some with a concurrent mid-frame write
    for (int it = 0; it < 8; it++) begin
      for (int k = 0; k < 3; k++) put_bin($urandom_range(0, NB-1), $urandom_range(0, 7));
      exp = model_mask(mshadow[0], mshadow[1]);
      o = dflt();
      if ($urandom_range(0, 1) == 1) begin
        o.wr_at = $urandom_range(0, 31); o.wr_idx = $urandom_range(0, NB-1);
        o.wr_h = $urandom_range(0, 7);
      end
      run_frame(o, r);
      check_full($sformatf("rand%0d", it), r, exp);
      if (o.wr_at >= 0) mshadow[o.wr_idx] = (o.wr_h > H) ? H : o.wr_h;
    end

    // Out-of-range index on the 3-bar instance
    mask3 = '0;
    bin_wr_en3 = 1'b1;
    bin_idx3 = 2'd0; bin_height = 3'd2; @(posedge wrclk); #1;
    bin_idx3 = 2'd2; bin_height = 3'd4; @(posedge wrclk); #1;
    bin_idx3 = 2'd3; bin_height = 3'd1; @(posedge wrclk); #1;
    bin_wr_en3 = 1'b0;
    start3 = 1'b1; @(posedge wrclk); #1; start3 = 1'b0;
    got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      if (done3) got = 1;
      else begin @(posedge wrclk); #1; end
    end
    chk("idx3_done", 64'(got), 64'd1);
    chk("idx3_mask", 64'(mask3), 64'(model_mask3(2, 0, 4)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
